// File: rtl/bus_ctrl_8085_if.sv
// CPU-side bus of the 8085 controller: core strobes/status, demultiplexed
// address and data, and the memory/I/O strobes that the controller generates.
interface bus_ctrl_8085_if;
  logic        ALE;
  logic        IO_Mn;
  logic        S1;
  logic        S0;
  logic        RDn;
  logic        WRn;
  logic [7:0]  AD;
  logic [7:0]  A_HI;
  logic [7:0]  data_in;
  logic        READY;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        io_rd;
  logic        io_wr;
  logic        halt;
  logic        bus_err;

  modport slave (
    input  ALE, IO_Mn, S1, S0, RDn, WRn, AD, A_HI, mem_rdata,
    output data_in, READY, mem_addr, mem_wdata,
    output mem_rd, mem_wr, io_rd, io_wr, halt, bus_err
  );

  modport master (
    output ALE, IO_Mn, S1, S0, RDn, WRn, AD, A_HI, mem_rdata,
    input  data_in, READY, mem_addr, mem_wdata,
    input  mem_rd, mem_wr, io_rd, io_wr, halt, bus_err
  );
endinterface

// File: rtl/bus_ctrl_8085.sv
// 8085 bus controller: latches the address on ALE, inserts WAIT_STATES wait
// cycles, then issues one registered memory or I/O strobe per machine cycle.
module bus_ctrl_8085 #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [7:0]  INTA_OPCODE = 8'hFF
) (
  input  logic           clk,
  input  logic           rst,
  bus_ctrl_8085_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WAIT, ST_ACCESS} state_t;

  localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  type_q, type_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        halt_q, halt_d;
  logic        bus_err_q, bus_err_d;
  // {mem_rd, mem_wr, io_rd, io_wr}, only ever non-zero while in ACCESS
  logic [3:0]  strobe_q, strobe_d;

  logic is_inta;
  logic type_rd;
  logic type_wr;

  assign is_inta = (type_q == 3'b111);
  assign type_rd = (type_q == 3'b011) || (type_q == 3'b010) || (type_q == 3'b110);
  assign type_wr = (type_q == 3'b001) || (type_q == 3'b101);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    type_d    = type_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;
    halt_d    = halt_q;
    bus_err_d = bus_err_q;
    strobe_d  = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (bus.ALE) begin
          addr_d = {bus.A_HI, bus.AD};
          type_d = {bus.IO_Mn, bus.S1, bus.S0};
          wcnt_d = WCNT_INIT;
          if ({bus.IO_Mn, bus.S1, bus.S0} == 3'b000) begin
            halt_d = 1'b1;
          end else begin
            halt_d  = 1'b0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        rd_req_d = !bus.RDn;
        wr_req_d = !bus.WRn;
        if (!bus.WRn) wdata_d = bus.AD;
        state_d = (wcnt_q != 4'd0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (is_inta && !(rd_req_q && wr_req_q)) begin
          data_in_d = INTA_OPCODE;
        end else if (strobe_q[3] || strobe_q[1]) begin
          data_in_d = bus.mem_rdata;
        end
        // A non-INTA access that reached ACCESS without a strobe was illegal
        if ((rd_req_q && wr_req_q) || (!is_inta && strobe_q == 4'b0000)) begin
          bus_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.ALE && state_q != ST_IDLE) bus_err_d = 1'b1;

    // Strobes are registered on entry to ACCESS so the outputs come straight off flops
    if (state_d == ST_ACCESS) begin
      if (rd_req_d && !wr_req_d && type_rd) begin
        strobe_d = type_q[2] ? 4'b0010 : 4'b1000;
      end else if (wr_req_d && !rd_req_d && type_wr) begin
        strobe_d = type_q[2] ? 4'b0001 : 4'b0100;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      type_q    <= 3'b000;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      data_in_q <= 8'h00;
      halt_q    <= 1'b0;
      bus_err_q <= 1'b0;
      strobe_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      type_q    <= type_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
      halt_q    <= halt_d;
      bus_err_q <= bus_err_d;
      strobe_q  <= strobe_d;
    end
  end

  assign bus.READY     = (state_q != ST_WAIT);
  assign bus.data_in   = data_in_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = strobe_q[3];
  assign bus.mem_wr    = strobe_q[2];
  assign bus.io_rd     = strobe_q[1];
  assign bus.io_wr     = strobe_q[0];
  assign bus.halt      = halt_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_ctrl_8085.sv
// Directed bench for bus_ctrl_8085: three instances with 0, 3 and 4 wait states
// share stimulus, and ALE is steered to one instance at a time.
module tb_bus_ctrl_8085;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ale = 1'b0;
  logic [2:0] typ = 3'b000;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic [7:0] ad = 8'h00;
  logic [7:0] a_hi = 8'h00;
  logic [7:0] rdata = 8'h00;
  int         sel = 0;

  logic [2:0]        ready_w;
  logic [2:0]        halt_w;
  logic [2:0]        err_w;
  logic [2:0][7:0]   din_w;
  logic [2:0][7:0]   wdat_w;
  logic [2:0][15:0]  addr_w;
  logic [2:0][3:0]   strb_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    bus_ctrl_8085_if bif ();
    assign bif.ALE       = ale && (sel == gi);
    assign bif.IO_Mn     = typ[2];
    assign bif.S1        = typ[1];
    assign bif.S0        = typ[0];
    assign bif.RDn       = rdn;
    assign bif.WRn       = wrn;
    assign bif.AD        = ad;
    assign bif.A_HI      = a_hi;
    assign bif.mem_rdata = rdata;
    assign ready_w[gi]   = bif.READY;
    assign halt_w[gi]    = bif.halt;
    assign err_w[gi]     = bif.bus_err;
    assign din_w[gi]     = bif.data_in;
    assign wdat_w[gi]    = bif.mem_wdata;
    assign addr_w[gi]    = bif.mem_addr;
    assign strb_w[gi]    = {bif.mem_rd, bif.mem_wr, bif.io_rd, bif.io_wr};

    bus_ctrl_8085 #(
      .WAIT_STATES((gi == 0) ? 0 : (gi == 1) ? 3 : 4),
      .INTA_OPCODE(8'hFF)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
    );
  end

  typedef struct {
    logic [2:0]  typ;
    logic [7:0]  a_hi;
    logic [7:0]  ad_ale;
    logic [7:0]  ad_addr;
    logic        rdn;
    logic        wrn;
    logic [7:0]  rdata;
    logic [3:0]  exp_strb;
    logic [7:0]  exp_din;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_halt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one zero-wait transaction on instance 0, starting just after a negedge
  task automatic run_txn(input int i);
    vec_t v;
    v = vecs[i];
    sel  = 0;
    ale  = 1'b1;
    typ  = v.typ;
    a_hi = v.a_hi;
    ad   = v.ad_ale;
    rdn  = 1'b1;
    wrn  = 1'b1;
    @(negedge clk);
    ale = 1'b0;
    chk($sformatf("v%0d addr_latch", i), 32'(addr_w[0]), 32'(v.exp_addr));
    chk($sformatf("v%0d halt_latch", i), 32'(halt_w[0]), 32'(v.typ == 3'b000));
    chk($sformatf("v%0d strb_addr", i), 32'(strb_w[0]), 32'd0);
    rdn   = v.rdn;
    wrn   = v.wrn;
    ad    = v.ad_addr;
    rdata = v.rdata;
    @(negedge clk);
    chk($sformatf("v%0d strb_access", i), 32'(strb_w[0]), 32'(v.exp_strb));
    chk($sformatf("v%0d ready", i), 32'(ready_w[0]), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d strb_after", i), 32'(strb_w[0]), 32'd0);
    chk($sformatf("v%0d data_in", i), 32'(din_w[0]), 32'(v.exp_din));
    chk($sformatf("v%0d bus_err", i), 32'(err_w[0]), 32'(v.exp_err));
    chk($sformatf("v%0d wdata", i), 32'(wdat_w[0]), 32'(v.exp_wdata));
    chk($sformatf("v%0d halt", i), 32'(halt_w[0]), 32'(v.exp_halt));
    chk($sformatf("v%0d addr_hold", i), 32'(addr_w[0]), 32'(v.exp_addr));
    rdn = 1'b1;
    wrn = 1'b1;
    $display("txn v%0d type=%b addr=%h strb=%b data_in=%h err=%b",
             i, v.typ, addr_w[0], v.exp_strb, din_w[0], err_w[0]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           typ     a_hi   ad_ale ad_addr rdn   wrn   rdata  strb     din    addr      wdata  halt  err
    vecs[0] = '{3'b010, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 8'hA5, 4'b1000, 8'hA5, 16'h1234, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{3'b011, 8'h00, 8'h10, 8'h00, 1'b0, 1'b1, 8'h3E, 4'b1000, 8'h3E, 16'h0010, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{3'b110, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 8'h5A, 4'b0010, 8'h5A, 16'h8080, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{3'b101, 8'h40, 8'h40, 8'h77, 1'b1, 1'b0, 8'h00, 4'b0001, 8'h5A, 16'h4040, 8'h77, 1'b0, 1'b0};
    vecs[4] = '{3'b001, 8'hAB, 8'hCD, 8'h99, 1'b1, 1'b0, 8'h00, 4'b0100, 8'h5A, 16'hABCD, 8'h99, 1'b0, 1'b0};
    vecs[5] = '{3'b111, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h12, 4'b0000, 8'hFF, 16'h0000, 8'h99, 1'b0, 1'b0};
    vecs[6] = '{3'b000, 8'h12, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 4'b0000, 8'hFF, 16'h1200, 8'h99, 1'b1, 1'b0};
    vecs[7] = '{3'b010, 8'h20, 8'h00, 8'h44, 1'b0, 1'b0, 8'h11, 4'b0000, 8'hFF, 16'h2000, 8'h44, 1'b0, 1'b1};
    vecs[8] = '{3'b001, 8'h30, 8'h00, 8'h55, 1'b0, 1'b1, 8'h22, 4'b0000, 8'hFF, 16'h3000, 8'h44, 1'b0, 1'b1};

    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ready", 32'(ready_w[0]), 32'd1);
    chk("reset data_in", 32'(din_w[0]), 32'd0);
    chk("reset addr", 32'(addr_w[0]), 32'd0);
    chk("reset wdata", 32'(wdat_w[0]), 32'd0);
    chk("reset strobes", 32'(strb_w[0]), 32'd0);
    chk("reset halt", 32'(halt_w[0]), 32'd0);
    chk("reset bus_err", 32'(err_w[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(i);

    // Memory write with 3 wait states: READY low for exactly 3 cycles
    sel = 1; ale = 1'b1; typ = 3'b001; a_hi = 8'h12; ad = 8'h34;
    @(negedge clk);
    ale = 1'b0; ad = 8'h5C; wrn = 1'b0;
    chk("ws3 ready_addr", 32'(ready_w[1]), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("ws3 ready_wait%0d", c), 32'(ready_w[1]), 32'd0);
      chk($sformatf("ws3 strb_wait%0d", c), 32'(strb_w[1]), 32'd0);
    end
    @(negedge clk);
    chk("ws3 ready_access", 32'(ready_w[1]), 32'd1);
    chk("ws3 mem_wr", 32'(strb_w[1]), 32'b0100);
    chk("ws3 wdata", 32'(wdat_w[1]), 32'h5C);
    @(negedge clk);
    wrn = 1'b1;
    chk("ws3 strb_after", 32'(strb_w[1]), 32'd0);
    chk("ws3 data_in", 32'(din_w[1]), 32'd0);
    chk("ws3 bus_err", 32'(err_w[1]), 32'd0);
    $display("txn ws3 write addr=%h wdata=%h", addr_w[1], wdat_w[1]);

    // ALE while busy: flagged, but the read still completes unchanged
    ale = 1'b1; typ = 3'b010; a_hi = 8'h56; ad = 8'h78;
    @(negedge clk);
    ale = 1'b0; rdn = 1'b0; rdata = 8'hC3;
    @(negedge clk);
    ale = 1'b1; a_hi = 8'hFF; ad = 8'hFF; typ = 3'b110;
    @(negedge clk);
    ale = 1'b0; typ = 3'b010;
    chk("busy bus_err", 32'(err_w[1]), 32'd1);
    chk("busy addr", 32'(addr_w[1]), 32'h5678);
    @(negedge clk);
    chk("busy still_wait", 32'(ready_w[1]), 32'd0);
    @(negedge clk);
    chk("busy mem_rd", 32'(strb_w[1]), 32'b1000);
    @(negedge clk);
    rdn = 1'b1;
    chk("busy data_in", 32'(din_w[1]), 32'hC3);
    chk("busy strb_after", 32'(strb_w[1]), 32'd0);
    $display("txn busy-ale read addr=%h data_in=%h err=%b", addr_w[1], din_w[1], err_w[1]);

    // Asynchronous reset in the middle of a 4-wait-state write
    sel = 2; ale = 1'b1; typ = 3'b001; a_hi = 8'h00; ad = 8'h10;
    @(negedge clk);
    ale = 1'b0; wrn = 1'b0; ad = 8'h66;
    @(negedge clk);
    chk("rst4 ready_wait", 32'(ready_w[2]), 32'd0);
    chk("rst4 wdata_pre", 32'(wdat_w[2]), 32'h66);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst4 ready_now", 32'(ready_w[2]), 32'd1);
    chk("rst4 strobes_now", 32'(strb_w[2]), 32'd0);
    chk("rst4 addr_now", 32'(addr_w[2]), 32'd0);
    chk("rst4 wdata_now", 32'(wdat_w[2]), 32'd0);
    chk("rst4 din3_now", 32'(din_w[1]), 32'd0);
    chk("rst4 err0_now", 32'(err_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rst4 post_strb%0d", c), 32'(strb_w[2]), 32'd0);
      chk($sformatf("rst4 post_ready%0d", c), 32'(ready_w[2]), 32'd1);
    end
    wrn = 1'b1;
    $display("txn reset-mid-wait ready=%b strobes=%b", ready_w[2], strb_w[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
